// File: rtl/twg_pkg.sv
// Shared types and helpers for the crank/cam trigger-wheel emulator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package twg_pkg;

  // Tooth phase: first half (vr low), second half (vr high), and the
  // extended tail of the last real tooth that swallows the missing teeth.
  typedef enum logic [1:0] {
    TOOTH_LO = 2'd0,
    TOOTH_HI = 2'd1,
    GAP      = 2'd2
  } twg_state_e;

  // Shortest tooth that still gives a distinct low and high half.
  localparam int TWG_MIN_PER = 4;

  // Length of the last real tooth: its own period plus every missing tooth.
  function automatic logic [31:0] gap_len(input logic [31:0] per, input int missing);
    return per * 32'(missing + 1);
  endfunction

endpackage

// File: rtl/twg_tooth_timer.sv
// Tooth timer: latches the tooth period, counts cycles in a tooth, flags tooth end and vr level.
// Latency: tooth_end is combinational on cnt; vr is registered one cycle after the cnt it reflects.
// Backpressure: none; en=0 freezes cnt/state and forces vr low on the next cycle.
//
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   en         advance enable
//   period     requested cycles per tooth (clamped to TWG_MIN_PER)
//   gap_tooth  current tooth is the last real tooth (absorbs the gap)
//   tooth_end  high in the last cycle of the current tooth (only when en)
//   vr         crank level
module twg_tooth_timer
  import twg_pkg::*;
#(
  parameter int MISSING = 2,
  parameter int PER_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [PER_W-1:0] period,
  input  logic             gap_tooth,
  output logic             tooth_end,
  output logic             vr
);

  // Wide enough for (MISSING+1)*max_period, so the gap tooth never overflows.
  localparam int CW = PER_W + $clog2(MISSING + 2);

  logic [PER_W-1:0] per_q;
  logic [PER_W-1:0] per_clamp;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [CW-1:0]    per_ext;
  logic [CW-1:0]    half;
  logic [CW-1:0]    len;
  logic [31:0]      gap_len32;
  logic             first_q;
  twg_state_e       state;
  twg_state_e       state_nxt;

  assign per_clamp = (period < PER_W'(TWG_MIN_PER)) ? PER_W'(TWG_MIN_PER) : period;
  assign per_ext   = CW'(per_q);
  assign half      = CW'(per_q >> 1);
  assign gap_len32 = gap_len(32'(per_q), MISSING);
  assign len       = gap_tooth ? gap_len32[CW-1:0] : per_ext;
  assign tooth_end = en && (cnt == len - CW'(1));
  assign cnt_nxt   = tooth_end ? '0 : cnt + CW'(1);

  // State tracks the cnt value it will sit beside, so vr can be a plain
  // registered copy of (state == TOOTH_HI). per_q only changes at a tooth
  // boundary or on cnt 0->1, where the next state is TOOTH_LO either way.
  always_comb begin
    state_nxt = TOOTH_LO;
    if (tooth_end)
      state_nxt = TOOTH_LO;
    else if (cnt_nxt < half)
      state_nxt = TOOTH_LO;
    else if (cnt_nxt < per_ext)
      state_nxt = TOOTH_HI;
    else
      state_nxt = GAP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      per_q   <= PER_W'(TWG_MIN_PER);
      first_q <= 1'b1;
      cnt     <= '0;
      state   <= TOOTH_LO;
      vr      <= 1'b0;
    end else begin
      vr <= en && (state == TOOTH_HI);
      if (en) begin
        first_q <= 1'b0;
        // New period applies from the next tooth; the first enabled cycle
        // after reset also picks it up so the first tooth is not stuck at 4.
        if (tooth_end || first_q)
          per_q <= per_clamp;
        cnt   <= cnt_nxt;
        state <= state_nxt;
      end
    end
  end

endmodule

// File: rtl/trigger_wheel_gen.sv
// Crank/cam trigger-wheel emulator: TEETH-minus-MISSING crank wheel plus optional 720-degree cam.
// Latency: all outputs registered; vr_out lags the tooth counter by one cycle.
// Backpressure: none; en=0 freezes the pattern (vr_out low, rev_stb low), en=1 resumes in place.
//
// Build option: define TWG_CAM_EN to generate the cam signal; otherwise cam_out is tied high.
// Ports:
//   clk, rst   system clock, synchronous active-high reset
//   en         run enable
//   period     clk cycles per tooth, taken at each tooth boundary
//   vr_out     crank output (low first half of tooth, high second half)
//   cam_out    cam output
//   tooth_idx  current real tooth 0..TEETH-MISSING-1
//   rev_stb    one-cycle pulse in the first cycle of tooth 0
//   gap_act    high for the whole last real tooth including the gap
module trigger_wheel_gen
  import twg_pkg::*;
#(
  parameter int TEETH       = 60,
  parameter int MISSING     = 2,
  parameter int PER_W       = 16,
  parameter int START_TOOTH = 0,
  parameter int CAM_FALL    = 54,
  parameter int CAM_RISE    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [PER_W-1:0]         period,
  output logic                     vr_out,
  output logic                     cam_out,
  output logic [$clog2(TEETH)-1:0] tooth_idx,
  output logic                     rev_stb,
  output logic                     gap_act
);

  localparam int            IW   = $clog2(TEETH);
  localparam logic [IW-1:0] LAST = IW'(TEETH - MISSING - 1);

  logic          tooth_end;
  logic          wrap;
  logic [IW-1:0] idx_nxt;

  assign wrap    = (tooth_idx == LAST);
  assign idx_nxt = wrap ? '0 : tooth_idx + IW'(1);

  // gap_act always mirrors (tooth_idx == LAST), so it doubles as the timer's
  // gap-tooth select without another comparator.
  twg_tooth_timer #(
    .MISSING (MISSING),
    .PER_W   (PER_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .period    (period),
    .gap_tooth (gap_act),
    .tooth_end (tooth_end),
    .vr        (vr_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      tooth_idx <= IW'(START_TOOTH);
      rev_stb   <= 1'b0;
      gap_act   <= (IW'(START_TOOTH) == LAST);
    end else begin
      rev_stb <= tooth_end && wrap;
      if (tooth_end) begin
        tooth_idx <= idx_nxt;
        gap_act   <= (idx_nxt == LAST);
      end
    end
  end

`ifdef TWG_CAM_EN
  // cam_phase marks odd crank revolutions; the cam edges use the phase of
  // the tooth being entered, so they land in the same cycle as tooth_idx.
  logic cam_phase;
  logic cam_phase_nxt;

  assign cam_phase_nxt = wrap ? ~cam_phase : cam_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      cam_phase <= 1'b0;
      cam_out   <= 1'b1;
    end else if (tooth_end) begin
      cam_phase <= cam_phase_nxt;
      if ((idx_nxt == IW'(CAM_FALL)) && cam_phase_nxt)
        cam_out <= 1'b0;
      else if ((idx_nxt == IW'(CAM_RISE)) && !cam_phase_nxt)
        cam_out <= 1'b1;
    end
  end
`else
  assign cam_out = 1'b1;
`endif

endmodule

// File: tb/tb_trigger_wheel_gen.sv
module tb_trigger_wheel_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] period;
  logic        vr_out;
  logic        cam_out;
  logic [5:0]  tooth_idx;
  logic        rev_stb;
  logic        gap_act;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  trigger_wheel_gen dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .period    (period),
    .vr_out    (vr_out),
    .cam_out   (cam_out),
    .tooth_idx (tooth_idx),
    .rev_stb   (rev_stb),
    .gap_act   (gap_act)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int t);
    while (cyc < t) step();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_vr"},   32'(vr_out),    0);
    check({tag, "_cam"},  32'(cam_out),   1);
    check({tag, "_idx"},  32'(tooth_idx), 0);
    check({tag, "_rev"},  32'(rev_stb),   0);
    check({tag, "_gap"},  32'(gap_act),   0);
  endtask

  initial begin
    int  rises;
    int  highs;
    int  revs;
    logic prev_vr;

    // ---- reset state ----
    rst = 1'b1; en = 1'b0; period = 16'd64;
    repeat (4) @(posedge clk);
    #1;
    check_reset("reset");

    // ---- one full revolution at period 64 ----
    rst = 1'b0; en = 1'b1; cyc = 0;
    rises = 0; highs = 0; revs = 0; prev_vr = 1'b0;
    while (cyc < 3840) begin
      step();
      if (vr_out && !prev_vr) rises++;
      if (vr_out) highs++;
      if (rev_stb) revs++;
      prev_vr = vr_out;
      if (cyc == 32)   check("t0_vr_low_end",   32'(vr_out), 0);
      if (cyc == 33)   check("t0_vr_high_start", 32'(vr_out), 1);
      if (cyc == 63)   check("t0_idx_hold",      32'(tooth_idx), 0);
      if (cyc == 64)   check("t0_idx_adv",       32'(tooth_idx), 1);
      if (cyc == 65)   check("t1_vr_low",        32'(vr_out), 0);
      if (cyc == 3647) check("gap_act_before",   32'(gap_act), 0);
      if (cyc == 3648) check("gap_act_on",       32'(gap_act), 1);
      if (cyc == 3680) check("t57_vr_low",       32'(vr_out), 0);
      if (cyc == 3681) check("t57_vr_high",      32'(vr_out), 1);
      if (cyc == 3712) check("t57_vr_high_end",  32'(vr_out), 1);
      if (cyc == 3713) check("t57_gap_low",      32'(vr_out), 0);
      if (cyc == 3839) check("t57_rev_low",      32'(rev_stb), 0);
      if (cyc == 3839) check("t57_idx",          32'(tooth_idx), 57);
    end
    check("rev_stb_pulse", 32'(rev_stb), 1);
    check("rev_idx_wrap",  32'(tooth_idx), 0);
    check("rev_gap_off",   32'(gap_act), 0);
    check("rev_vr_low",    32'(vr_out), 0);
    check("pulses_per_rev", 32'(rises), 58);
    check("high_cycles",    32'(highs), 1856);
    check("rev_stb_count",  32'(revs), 1);
    step();
    check("rev_stb_one_cycle", 32'(rev_stb), 0);

    // ---- period change mid-tooth 5 ----
    run_to(4170);
    check("t5_idx", 32'(tooth_idx), 5);
    period = 16'd100;
    run_to(4223); check("t5_len64_hold", 32'(tooth_idx), 5);
    run_to(4224); check("t5_len64_adv",  32'(tooth_idx), 6);
    run_to(4274); check("t6_vr_low",     32'(vr_out), 0);
    run_to(4275); check("t6_vr_high",    32'(vr_out), 1);
    run_to(4323); check("t6_len100_hold", 32'(tooth_idx), 6);
    run_to(4324); check("t6_len100_adv",  32'(tooth_idx), 7);

    // ---- freeze mid-tooth 20 ----
    run_to(5694);
    check("t20_idx", 32'(tooth_idx), 20);
    check("t20_vr_before_freeze", 32'(vr_out), 1);
    en = 1'b0;
    run_to(5695); check("freeze_vr_forced", 32'(vr_out), 0);
    run_to(5744);
    check("freeze_vr_end",  32'(vr_out), 0);
    check("freeze_idx",     32'(tooth_idx), 20);
    check("freeze_rev",     32'(rev_stb), 0);
    en = 1'b1;
    run_to(5745); check("resume_vr", 32'(vr_out), 1);
    run_to(5773); check("resume_idx_hold", 32'(tooth_idx), 20);
    run_to(5774); check("resume_idx_adv",  32'(tooth_idx), 21);

    // ---- reset mid-tooth 30 ----
    run_to(6754);
    check("t30_idx", 32'(tooth_idx), 30);
    check("t30_vr",  32'(vr_out), 1);
    rst = 1'b1;
    step();
    check_reset("midrst");

    // ---- clamped period ----
    period = 16'd1;
    step();
    rst = 1'b0; cyc = 0;
    run_to(2);   check("clamp_vr_low",   32'(vr_out), 0);
    run_to(3);   check("clamp_vr_high",  32'(vr_out), 1);
    check("clamp_idx_hold", 32'(tooth_idx), 0);
    run_to(4);   check("clamp_idx_adv",  32'(tooth_idx), 1);
    run_to(5);   check("clamp_vr_low2",  32'(vr_out), 0);
    run_to(216); check("cam_rev0_t54",   32'(cam_out), 1);
    run_to(228);
    check("clamp_t57",     32'(tooth_idx), 57);
    check("clamp_gap_act", 32'(gap_act), 1);
    run_to(232); check("clamp_gap_vr_high", 32'(vr_out), 1);
    run_to(233); check("clamp_gap_vr_low",  32'(vr_out), 0);
    run_to(239);
    check("clamp_gap_vr_tail", 32'(vr_out), 0);
    check("clamp_gap_rev_low", 32'(rev_stb), 0);
    run_to(240);
    check("clamp_rev_stb", 32'(rev_stb), 1);
    check("clamp_wrap",    32'(tooth_idx), 0);

    // ---- cam over two revolutions (period 4 -> 240 cycles/rev) ----
`ifdef TWG_CAM_EN
    run_to(455); check("cam_before_fall", 32'(cam_out), 1);
    run_to(456); check("cam_fall_t54",    32'(cam_out), 0);
    run_to(495); check("cam_before_rise", 32'(cam_out), 0);
    run_to(496); check("cam_rise_t4",     32'(cam_out), 1);
`else
    run_to(455); check("cam_const_a", 32'(cam_out), 1);
    run_to(456); check("cam_const_b", 32'(cam_out), 1);
    run_to(495); check("cam_const_c", 32'(cam_out), 1);
    run_to(496); check("cam_const_d", 32'(cam_out), 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
